// File: rtl/dot_seq_if.sv
// dot_seq_if: command, operand-buffer and MAC signals of the dot-product sequencer.
// master is the surrounding host/buffer/MAC side, slave is the sequencer itself.
interface dot_seq_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [15:0]       rd_data_a;
  logic [15:0]       rd_data_b;
  logic              mac_enable;
  logic              mac_clear;
  logic [15:0]       mac_a;
  logic [15:0]       mac_b;
  logic [15:0]       mac_result;
  logic              busy;
  logic              done;
  logic [15:0]       result;
  modport master (
    output start, abort, len, base_a, base_b, rd_data_a, rd_data_b, mac_result,
    input  rd_en, rd_addr_a, rd_addr_b, mac_enable, mac_clear, mac_a, mac_b, busy, done, result
  );
  modport slave (
    input  start, abort, len, base_a, base_b, rd_data_a, rd_data_b, mac_result,
    output rd_en, rd_addr_a, rd_addr_b, mac_enable, mac_clear, mac_a, mac_b, busy, done, result
  );
endinterface

// File: rtl/dot_seq_ctrl.sv
// dot_seq_ctrl: streams two operand vectors from synchronous-read buffers into a MAC,
// one dot product per command, and captures the MAC result on completion.
module dot_seq_ctrl #(
  parameter int ADDR_W = 8
) (
  input logic     clk,
  input logic     rst_n,
  dot_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPT, DONE} state_t;
  state_t            state, nxt;
  logic [ADDR_W:0]   len_q, idx;
  logic [ADDR_W-1:0] ba_q, bb_q;
  logic [15:0]       res_q;
  logic              accept, clr, run, capt;
  assign accept = (state == IDLE || state == DONE) && bus.start;
  assign clr    = state == CLEAR;
  assign run    = state == RUN;
  assign capt   = state == CAPT;
  // idx is the element being addressed: 0 in CLEAR, j+1 in RUN cycle j
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      idx   <= '0;
      ba_q  <= '0;
      bb_q  <= '0;
      res_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        len_q <= bus.len;
        ba_q  <= bus.base_a;
        bb_q  <= bus.base_b;
        idx   <= '0;
      end else if (clr || run) begin
        idx <= idx + 1'b1;
      end
      if (capt && !bus.abort) res_q <= bus.mac_result;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? CLEAR : IDLE;
      CLEAR:   nxt = bus.abort ? IDLE : (len_q == '0 ? CAPT : RUN);
      RUN:     nxt = bus.abort ? IDLE : (idx == len_q ? CAPT : RUN);
      CAPT:    nxt = bus.abort ? IDLE : DONE;
      DONE:    nxt = bus.start ? CLEAR : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign bus.rd_en      = (clr || run) && idx < len_q;
  assign bus.rd_addr_a  = bus.rd_en ? ba_q + idx[ADDR_W-1:0] : '0;
  assign bus.rd_addr_b  = bus.rd_en ? bb_q + idx[ADDR_W-1:0] : '0;
  assign bus.mac_enable = clr || run;
  assign bus.mac_clear  = clr;
  assign bus.mac_a      = run ? bus.rd_data_a : '0;
  assign bus.mac_b      = run ? bus.rd_data_b : '0;
  assign bus.busy       = clr || run || capt;
  assign bus.done       = state == DONE;
  assign bus.result     = res_q;
endmodule

// File: doc/dot_seq_ctrl.md
# dot_seq_ctrl

Sequencer that computes one fixed-point (Q5.10) dot product per command by streaming two operand vectors out of synchronous-read buffers into a single downstream `mac_unit`. It issues buffer addresses, drives the MAC `enable`/`clear`/`a`/`b` inputs, captures the final 16-bit MAC result and reports completion. It sits between the command/host logic and the MAC datapath inside the compute array.

## Interface
- `ADDR_W`, 8: operand buffer address width; vectors up to 2^ADDR_W elements.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE or DONE.
- `abort`  in  1  synchronous cancel of the current command.
- `len`  in  ADDR_W+1  element count, latched on accepted `start`.
- `base_a`, `base_b`  in  ADDR_W each  start addresses, latched on accepted `start`.
- `rd_en`  out  1  read strobe to both buffers.
- `rd_addr_a`, `rd_addr_b`  out  ADDR_W each  read addresses.
- `rd_data_a`, `rd_data_b`  in  16 each  buffer data, valid one cycle after `rd_en`.
- `mac_enable`, `mac_clear`  out  1 each  to MAC.
- `mac_a`, `mac_b`  out  16 each  MAC operands.
- `mac_result`  in  16  MAC registered result.
- `busy`  out  1  high in CLEAR, RUN, CAPT.
- `done`  out  1  one-cycle pulse, DONE state.
- `result`  out  16  captured dot product, held until next capture.

## Operation
- States: IDLE, CLEAR, RUN, CAPT, DONE. Reset -> IDLE; all outputs 0, `result`=0, counters 0.
- IDLE/DONE + `start`=1 -> CLEAR; latch `len`, `base_a`, `base_b`; index counter := 0. DONE without `start` -> IDLE.
- CLEAR (1 cycle): `mac_enable`=1, `mac_clear`=1, `mac_a`=`mac_b`=0. If len>0: `rd_en`=1, address element 0. Next: RUN if len>0, else CAPT.
- RUN (exactly len cycles, j=0..len-1): `mac_enable`=1, `mac_clear`=0, `mac_a`=`rd_data_a`, `mac_b`=`rd_data_b` (element j). `rd_en`=1 issuing element j+1 while j+1<len, else 0. After j=len-1 -> CAPT.
- CAPT (1 cycle): `mac_enable`=0; `result` := `mac_result` at end of cycle. -> DONE.
- DONE (1 cycle): `done`=1, `busy`=0.
- Addresses: `rd_addr_x` = base_x + index, modulo 2^ADDR_W (wrap, no error). `rd_addr_*` = 0 when `rd_en`=0.
- Outside CLEAR/RUN: `mac_enable`=`mac_clear`=0, `mac_a`=`mac_b`=0.
- `abort`=1 in CLEAR/RUN/CAPT -> IDLE next cycle; no `done`, `result` unchanged, `mac_enable`=0 from that next cycle. `abort` in IDLE/DONE ignored; `abort` and `start` together in DONE: `abort` ignored, start accepted.
- `start` during busy ignored (no queueing).
- No arithmetic in this block; MAC accumulation/truncation semantics (product >>>10, 16-bit wrap of result) are owned by the MAC.

## Timing
- Start accepted at edge E0. CLEAR = cycle 1, RUN = cycles 2..len+1, CAPT = cycle len+2, DONE (`done`=1, `result` valid) = cycle len+3.
- len=0: CLEAR, CAPT, DONE; `done` at cycle 3, `result`=0.
- Buffer read latency fixed at 1 cycle; no stall input.
- Back-to-back: `start` in DONE -> CLEAR next cycle, zero idle gap.
- `rst_n` low at any time: immediate return to IDLE, outputs 0, `result` cleared.

## Test plan
- len=3, A=[0x0400,0x0800,0xFC00], B=[0x0400,0x0200,0x0400] -> `mac_enable` high 4 cycles (first with clear), `done` at start+6, `result`=0x0400.
- len=0 -> single clear pulse, no `rd_en`, `done` at start+3, `result`=0x0000.
- base_a=0xFE, base_b=0x10, len=4 -> `rd_addr_a` sequence FE,FF,00,01; `rd_addr_b` 10..13.
- `abort` in RUN cycle j=1 of len=5 -> IDLE next cycle, no `done`, prior `result` retained; new start then runs normally.
- Two commands back-to-back (start held in DONE) -> second CLEAR immediately after DONE, both results correct, second not contaminated by first accumulation.
- `rst_n` asserted mid-RUN -> all outputs 0 asynchronously, `result`=0, `start` issued after release accepted.
